bcd_display: RTL and testbench

- Converts a 14-bit unsigned binary result into four BCD digits using a sequential double-dabble.
- Drives a 4-digit, time-multiplexed, active-low 7-segment display.
- Performs the reverse of the keypad number-entry path: it turns the binary operand or result back into decimal digits for the user.
- Sits between the arithmetic unit (producer of value_i/load_i) and the board display pins.

---
 rtl/bcd_display_pkg.sv | 36 +++
 rtl/bcd_display_seg7_decode.sv | 21 ++
 rtl/bcd_display.sv | 149 ++++++++++++++
 tb/tb_bcd_display.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD display path: FSM encoding, segment patterns
// and the single double-dabble step used by the converter.
package bcd_display_pkg;

  localparam int BIN_W    = 14;
  localparam int BCD_W    = 16;
  localparam int SHR_W    = BCD_W + BIN_W;
  localparam int BCD_ITER = 14;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // One iteration: correct every BCD nibble >= 5, then shift {bcd, bin} left.
  function automatic logic [SHR_W-1:0] dabble_step(input logic [SHR_W-1:0] r);
    logic [SHR_W-1:0] t;
    t = r;
    for (int i = 0; i < 4; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
        t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SHR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_display_seg7_decode.sv
// Combinational digit-to-segment lookup; dash wins over blank, blank over digit.
// Shared with the keypad echo display.
module seg7_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i && (digit_i <= 4'd9)) begin
      seg_o = SEG_DIGIT[digit_i];
    end
  end

endmodule

// File: rtl/bcd_display.sv
// Sequential double-dabble binary-to-BCD converter feeding a 4-digit,
// time-multiplexed, active-low 7-segment display.
module bcd_display
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value_i,
  input  logic             load_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [3:0]       an_o,
  output logic [6:0]       seg_o
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t             state_q, state_d;
  logic [SHR_W-1:0]   shreg_q, shreg_d;
  logic [3:0]         iter_q, iter_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;
  logic [1:0]         scan_q, scan_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  logic [3:0]         lz;
  logic [3:0]         dec_digit;
  logic               dec_blank;
  logic [6:0]         dec_seg;

  // Conversion FSM. busy is registered from the current state so it is high
  // for exactly the 14 cycles following the first shift edge.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    busy_d     = (state_q == ST_SHIFT);
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          shreg_d    = {{BCD_W{1'b0}}, value_i};
          iter_d     = 4'd0;
          ovf_pend_d = (value_i > 14'd9999);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = dabble_step(shreg_q);
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'(BCD_ITER - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        disp_d  = shreg_q[SHR_W-1:BIN_W];
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // lz[k] means digits k..3 are all zero; digit 0 is never blanked.
  always_comb begin
    lz[3] = (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    lz[0] = 1'b0;
  end

  // Scan: free-running counter; on wrap, advance the slot and register the
  // anode/segment pair for the slot being entered.
  always_comb begin
    rcnt_d    = rcnt_q + CNT_W'(1);
    scan_d    = scan_q;
    an_d      = an_q;
    seg_d     = seg_q;
    if (rcnt_q == CNT_LAST) begin
      rcnt_d = '0;
      scan_d = scan_q + 2'd1;
      an_d   = ~(4'b0001 << scan_d);
      seg_d  = dec_seg;
    end
  end

  always_comb begin
    dec_digit = disp_q[{scan_d, 2'b00} +: 4];
    dec_blank = BLANK_LZ && lz[scan_d];
  end

  seg7_decode u_dec (
    .digit_i (dec_digit),
    .blank_i (dec_blank),
    .dash_i  (ovf_q),
    .seg_o   (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      iter_q     <= 4'd0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rcnt_q     <= '0;
      scan_q     <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rcnt_q     <= rcnt_d;
      scan_q     <= scan_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;

endmodule

// File: tb/tb_bcd_display.sv
// Bench for bcd_display: two instances (leading-zero blanking on and off)
// share stimulus; expected digits come from decimal arithmetic on the value.
module tb_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value_i = '0;
  logic        load_i = 1'b0;

  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  int n_vec  = 0;
  int n_miss = 0;
  logic [6:0] pat [10];

  always #5 clk = ~clk;

  bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i),
    .busy_o(busy_a), .done_o(done_a), .ovf_o(ovf_a), .an_o(an_a), .seg_o(seg_a)
  );

  bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .value_i(value_i), .load_i(load_i),
    .busy_o(busy_b), .done_o(done_b), .ovf_o(ovf_b), .an_o(an_b), .seg_o(seg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference segment pattern for digit position k of value v.
  function automatic logic [6:0] exp_seg(input int v, input int k, input bit blz);
    int pw;
    pw = 10 ** k;
    if (v > 9999) return 7'b0111111;
    if (blz && k > 0 && v < pw) return 7'b1111111;
    return pat[(v / pw) % 10];
  endfunction

  // Walk all four scan slots of one instance and compare each against the model.
  task automatic check_display(input int v, input bit which_b);
    logic [3:0] ea;
    int n;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      ea = ~(4'b0001 << k);
      n = 0;
      while ((which_b ? an_b : an_a) !== ea && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (which_b) begin
        chk($sformatf("an_b v=%0d k=%0d", v, k), an_b, ea);
        chk($sformatf("seg_b v=%0d k=%0d", v, k), seg_b, exp_seg(v, k, 1'b0));
      end else begin
        chk($sformatf("an_a v=%0d k=%0d", v, k), an_a, ea);
        chk($sformatf("seg_a v=%0d k=%0d", v, k), seg_a, exp_seg(v, k, 1'b1));
      end
    end
  endtask

  // One load with cycle-by-cycle handshake checks. inj_c >= 1 re-pulses load
  // with inj_v in that cycle; rst_c >= 0 asserts reset in that cycle.
  task automatic do_load(input int v, input int inj_c, input int inj_v, input int rst_c);
    int dones;
    bit exp_busy, exp_done, live;
    dones = 0;
    @(negedge clk);
    value_i = 14'(v);
    load_i  = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 0) load_i = 1'b0;
      if (inj_c > 0 && c == inj_c) begin
        value_i = 14'(inj_v);
        load_i  = 1'b1;
      end else if (inj_c > 0 && c == inj_c + 1) begin
        load_i = 1'b0;
      end
      if (rst_c >= 0 && c == rst_c) begin
        rst = 1'b1;
        #1;
        chk("rst_an", an_a, 4'b1111);
        chk("rst_seg", seg_a, 7'b1111111);
        chk("rst_busy", busy_a, 1'b0);
        #1 rst = 1'b0;
      end
      live     = (rst_c < 0) || (c < rst_c);
      exp_busy = live && c >= 1 && c <= 14;
      exp_done = (rst_c < 0) && c == 15;
      chk($sformatf("busy v=%0d c=%0d", v, c), busy_a, exp_busy);
      chk($sformatf("done v=%0d c=%0d", v, c), done_a, exp_done);
      if (exp_done) begin
        chk($sformatf("ovf_a v=%0d", v), ovf_a, v > 9999);
        chk($sformatf("ovf_b v=%0d", v), ovf_b, v > 9999);
      end
      dones += int'(done_a);
    end
    chk($sformatf("done_count v=%0d", v), dones, (rst_c < 0) ? 1 : 0);
  endtask

  initial begin
    int v;
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000;

    // Reset, then confirm the display is dark before the first scan wrap.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_an", an_a, 4'b1111);
    chk("reset_seg", seg_a, 7'b1111111);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_done", done_a, 1'b0);
    chk("reset_ovf", ovf_a, 1'b0);
    check_display(0, 1'b0);

    do_load(1234, 0, 0, -1);  check_display(1234, 1'b0);
    do_load(7, 0, 0, -1);     check_display(7, 1'b0);   check_display(7, 1'b1);
    do_load(0, 0, 0, -1);     check_display(0, 1'b0);
    do_load(9999, 0, 0, -1);  check_display(9999, 1'b0);
    do_load(12000, 0, 0, -1); check_display(12000, 1'b0);
    do_load(5, 0, 0, -1);     check_display(5, 1'b0);
    do_load(500, 5, 300, -1); check_display(500, 1'b0);
    do_load(4321, 0, 0, 8);   check_display(0, 1'b0);
    do_load(42, 0, 0, -1);    check_display(42, 1'b0);  check_display(42, 1'b1);
    do_load(16383, 0, 0, -1); check_display(16383, 1'b1);
    do_load(10000, 0, 0, -1); check_display(10000, 1'b0);

    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
      do_load(v, 0, 0, -1);
      check_display(v, i[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
